trade_risk_ctrl: RTL and testbench
==================================

TRADE_RISK_CTRL -- requirements
Module: trade_risk_ctrl

Interface
REQ-001 SHALL have parameter READ_LAT, default 4, cycles from index presentation until mem_rdata is valid.
REQ-002 SHALL have parameter WRITE_LAT, default 6, cycles the memory is busy after a write strobe.
REQ-003 SHALL have parameter IDX_W, default 9, client index width.
REQ-004 SHALL have ports, clock and reset first:
 clk  in  1  single clock, all state on rising edge
 rst  in  1  asynchronous, active-high reset
 ord_valid  in  1  order/command present
 ord_ready  out  1  block accepts command this cycle
 ord_client  in  IDX_W  client index
 ord_setmax  in  1  1 = set-limit command, 0 = trade order
 ord_qty  in  16  trade quantity, or new limit when ord_setmax=1
 mem_rdindex  out  IDX_W  client index driven to per-client memory
 mem_we  out  1  one-cycle write strobe
 mem_wdata  out  32  write word: [31:16] limit, [15:0] quantity to accumulate
 mem_rdata  in  32  read word: [31:16] limit, [15:0] accumulated
 resp_valid  out  1  result available
 resp_ready  in  1  consumer takes result
 resp_client  out  IDX_W  echoed index
 resp_accept  out  1  1 = order/command committed
 resp_reason  out  2  0 ok, 1 over-limit, 2 bad limit, 3 sum overflow

Function
REQ-005 SHALL implement FSM states IDLE, READ, CHECK, WRITE, WAIT_WR, RESP.
REQ-006 IDLE: ord_ready=1; on ord_valid, SHALL latch client/setmax/qty, drive mem_rdindex=client, go to READ.
REQ-007 ord_ready SHALL be 0 in every state except IDLE; only one command in flight.
REQ-008 READ SHALL count READ_LAT cycles with mem_rdindex held, then capture mem_rdata and go to CHECK.
REQ-009 CHECK, trade: sum = 17-bit {0,acc} + {0,qty}; sum[16]=1 -> reject reason 3; sum[15:0] > limit -> reject reason 1; else accept.
REQ-010 CHECK, trade with qty=0: SHALL accept with reason 0 and skip WRITE.
REQ-011 CHECK, setmax with qty < 2: SHALL reject reason 2 (memory encoding treats limit ≤1 as accumulate).
REQ-012 Accept with nonzero write -> WRITE; any reject -> RESP, no write.
REQ-013 WRITE SHALL assert mem_we for exactly one cycle with mem_wdata={16'h0,qty} (trade) or {qty,16'h0} (setmax); mem_rdindex held.
REQ-014 WAIT_WR SHALL hold WRITE_LAT cycles, mem_we=0, then go to RESP.
REQ-015 RESP: resp_valid=1, outputs stable until resp_ready=1; handshake cycle returns to IDLE.
REQ-016 Latency ord accept -> resp_valid: READ_LAT+2 on reject/no-write path, READ_LAT+WRITE_LAT+3 on write path.
REQ-017 Limit equal to sum SHALL be accepted (strict greater-than rejects).
REQ-018 ord_valid outside IDLE SHALL be ignored; the source holds it until ord_ready.
REQ-019 Latency counter SHALL be sized for max(READ_LAT,WRITE_LAT) and never wrap.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE, ord_ready=1 after release, mem_we=0, mem_rdindex=0, mem_wdata=0, resp_valid=0, resp_accept=0, resp_reason=0, resp_client=0, counter=0.
REQ-021 Reset during WRITE/WAIT_WR SHALL drop mem_we immediately; the in-flight command is discarded, no response.

Structure
REQ-022 State enum, reason codes and the 32-bit entry field split (limit/acc) SHALL live in the shared cache_def package.
REQ-023 The latency counter SHALL be sub-module lat_counter (load value, done flag); everything else is flat.

Verification
REQ-024 Entry 5 = {0x0064,0x0050}; trade client 5 qty 0x0014 -> accept reason 0, one mem_we with wdata 0x00000014, sum exactly at limit.
REQ-025 Same entry, qty 0x0015 -> reject reason 1, no mem_we, resp_valid at READ_LAT+2 cycles.
REQ-026 Entry {0xFFFF,0xFFF0}, qty 0x0020 -> reject reason 3; setmax qty 0x0001 -> reject reason 2; setmax 0x0200 -> wdata 0x02000000.
REQ-027 Hold resp_ready=0 for 10 cycles -> resp fields stable, ord_ready=0 throughout; second ord_valid not taken until handshake.
REQ-028 Assert rst in WAIT_WR cycle 3 -> mem_we=0 same cycle, IDLE after release, no resp_valid.
REQ-029 Back-to-back 100 random orders vs scoreboard model of memory -> accept/reason and final accumulated values match.

Source files
------------

// File: rtl/cache_def.sv
// cache_def: shared types for the trade risk controller -- FSM states,
// response reason codes and the 32-bit per-client memory entry layout.
package cache_def;
    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_WRITE,
        S_WAIT_WR,
        S_RESP
    } state_t;

    typedef enum logic [1:0] {
        RSN_OK,
        RSN_OVER_LIMIT,
        RSN_BAD_LIMIT,
        RSN_SUM_OVF
    } reason_t;

    typedef struct packed {
        logic [15:0] limit;
        logic [15:0] acc;
    } entry_t;

    // The memory reads a limit field of 0 or 1 as "accumulate", so real limits start at 2.
    localparam int MIN_LIMIT = 2;

    function automatic int lat_max(int a, int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/lat_counter.sv
// lat_counter: loadable down-counter that saturates at zero; o_done is high
// while the count reads zero.
module lat_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_load_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end

    assign o_done = (r_cnt == '0);
endmodule

// File: rtl/trade_risk_ctrl.sv
// trade_risk_ctrl: per-client position-limit checker; reads a client's
// {limit, accumulated} word, accepts/rejects one order at a time, commits accepted ones.
module trade_risk_ctrl
    import cache_def::*;
#(
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 6,
    parameter int IDX_W     = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ord_valid,
    output logic             ord_ready,
    input  logic [IDX_W-1:0] ord_client,
    input  logic             ord_setmax,
    input  logic [15:0]      ord_qty,
    output logic [IDX_W-1:0] mem_rdindex,
    output logic             mem_we,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [IDX_W-1:0] resp_client,
    output logic             resp_accept,
    output logic [1:0]       resp_reason
);
    localparam int CNT_W = $clog2(lat_max(READ_LAT, WRITE_LAT) + 1);

    state_t           r_state, w_next;
    logic [IDX_W-1:0] r_client;
    logic             r_setmax;
    logic [15:0]      r_qty;
    entry_t           r_entry;
    logic             r_accept;
    reason_t          r_reason;
    logic [16:0]      w_sum;
    reason_t          w_reason;
    logic             w_write, w_done, w_load;
    logic [CNT_W-1:0] w_load_val;

    lat_counter #(.W(CNT_W)) u_lat (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_done)
    );

    // Bit 16 of the widened sum flags an accumulator overflow before the limit compare.
    assign w_sum    = {1'b0, r_entry.acc} + {1'b0, r_qty};
    assign w_reason = r_setmax ? ((r_qty < 16'(MIN_LIMIT)) ? RSN_BAD_LIMIT : RSN_OK)
                    : (r_qty == 16'd0) ? RSN_OK
                    : w_sum[16] ? RSN_SUM_OVF
                    : (w_sum[15:0] > r_entry.limit) ? RSN_OVER_LIMIT : RSN_OK;
    assign w_write  = (w_reason == RSN_OK) && (r_qty != 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    w_next = ord_valid ? S_READ : S_IDLE;
            S_READ:    w_next = w_done ? S_CHECK : S_READ;
            S_CHECK:   w_next = w_write ? S_WRITE : S_RESP;
            S_WRITE:   w_next = S_WAIT_WR;
            S_WAIT_WR: w_next = w_done ? S_RESP : S_WAIT_WR;
            S_RESP:    w_next = resp_ready ? S_IDLE : S_RESP;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ord_ready  = (r_state == S_IDLE);
        mem_we     = (r_state == S_WRITE);
        mem_wdata  = mem_we ? (r_setmax ? {r_qty, 16'h0} : {16'h0, r_qty}) : 32'h0;
        resp_valid = (r_state == S_RESP);
        w_load     = (ord_ready && ord_valid) || mem_we;
        w_load_val = mem_we ? CNT_W'(WRITE_LAT - 1) : CNT_W'(READ_LAT - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_client <= '0;
            r_setmax <= 1'b0;
            r_qty    <= '0;
            r_entry  <= '0;
            r_accept <= 1'b0;
            r_reason <= RSN_OK;
        end else begin
            if (ord_ready && ord_valid) begin
                r_client <= ord_client;
                r_setmax <= ord_setmax;
                r_qty    <= ord_qty;
            end
            if (r_state == S_READ && w_done)
                r_entry <= mem_rdata;
            if (r_state == S_CHECK) begin
                r_accept <= (w_reason == RSN_OK);
                r_reason <= w_reason;
            end
        end
    end

    assign mem_rdindex = r_client;
    assign resp_client = r_client;
    assign resp_accept = r_accept;
    assign resp_reason = r_reason;
endmodule

// File: tb/tb_trade_risk_ctrl.sv
// tb_trade_risk_ctrl: directed and random orders against a transaction-level
// limit model, with a behavioural per-client memory attached to the DUT.
module tb_trade_risk_ctrl;
    localparam int RL = 4;
    localparam int WL = 6;
    localparam int IW = 9;

    logic          clk = 0;
    logic          rst = 1;
    logic          ord_valid = 0;
    logic          ord_ready;
    logic [IW-1:0] ord_client = '0;
    logic          ord_setmax = 0;
    logic [15:0]   ord_qty = '0;
    logic [IW-1:0] mem_rdindex;
    logic          mem_we;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          resp_valid;
    logic          resp_ready = 0;
    logic [IW-1:0] resp_client;
    logic          resp_accept;
    logic [1:0]    resp_reason;

    always #5 clk = ~clk;

    trade_risk_ctrl #(.READ_LAT(RL), .WRITE_LAT(WL), .IDX_W(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ord_valid   (ord_valid),
        .ord_ready   (ord_ready),
        .ord_client  (ord_client),
        .ord_setmax  (ord_setmax),
        .ord_qty     (ord_qty),
        .mem_rdindex (mem_rdindex),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_client (resp_client),
        .resp_accept (resp_accept),
        .resp_reason (resp_reason)
    );

    // Memory: read data follows the index through RL-1 register stages; a write whose
    // limit field is 0/1 accumulates the low half, otherwise it replaces the limit.
    logic [31:0]   mem [0:511];
    logic [IW-1:0] rd_pipe [0:RL-2];
    logic          pl_en = 0, pl_clr = 0;
    logic [IW-1:0] pl_idx = '0;
    logic [31:0]   pl_data = '0;
    int            we_cnt = 0;
    logic [31:0]   last_wdata = '0;
    int            cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_pipe[0] <= mem_rdindex;
        for (int i = 1; i < RL - 1; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (pl_clr) begin
            for (int i = 0; i < 512; i++) mem[i] <= 32'h0;
        end else if (pl_en) begin
            mem[pl_idx] <= pl_data;
        end else if (mem_we) begin
            we_cnt <= we_cnt + 1;
            last_wdata <= mem_wdata;
            if (mem_wdata[31:16] > 16'd1) mem[mem_rdindex][31:16] <= mem_wdata[31:16];
            else mem[mem_rdindex][15:0] <= mem[mem_rdindex][15:0] + mem_wdata[15:0];
        end
    end
    assign mem_rdata = mem[rd_pipe[RL-2]];

    int m_lim [0:511];
    int m_acc [0:511];
    int checks = 0, failures = 0;
    bit busy = 0, chk_en = 0;
    int t_acc = 0;
    logic [IW-1:0] e_client = '0;
    int e_reason = 0, e_lat = 0;
    bit e_write = 0, e_accept = 0;
    logic [31:0] e_wdata = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h cyc=%0d", name, got, exp, cyc);
        end
    endtask

    task automatic preload(input int c, input logic [15:0] lim, input logic [15:0] acc);
        pl_en = 1; pl_idx = IW'(c); pl_data = {lim, acc};
        m_lim[c] = int'(lim); m_acc[c] = int'(acc);
        @(posedge clk); #1 pl_en = 0;
    endtask

    task automatic clear_all();
        pl_clr = 1;
        for (int i = 0; i < 512; i++) begin m_lim[i] = 0; m_acc[i] = 0; end
        @(posedge clk); #1 pl_clr = 0;
    endtask

    // Expected outcome comes from the limit rules applied to the model's own limit/acc.
    task automatic do_order(input int c, input bit s, input int q, input int hold,
                            output bit g_acc, output int g_rsn, output int g_lat);
        int n, sum;
        e_client = IW'(c);
        if (s) begin
            e_reason = (q < 2) ? 2 : 0; e_write = (q >= 2); e_wdata = {q[15:0], 16'h0};
        end else if (q == 0) begin
            e_reason = 0; e_write = 0; e_wdata = '0;
        end else begin
            sum = m_acc[c] + q;
            e_reason = (sum > 65535) ? 3 : (sum > m_lim[c]) ? 1 : 0;
            e_write = (e_reason == 0); e_wdata = {16'h0, q[15:0]};
        end
        e_accept = (e_reason == 0);
        e_lat = e_write ? RL + WL + 3 : RL + 2;
        ord_valid = 1; ord_client = IW'(c); ord_setmax = s; ord_qty = q[15:0];
        @(posedge clk); #1;
        ord_valid = 0; busy = 1; t_acc = cyc;
        n = 0;
        while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk("resp_arrives", 32'(resp_valid), 1);
        g_lat = cyc - t_acc + 1;
        if (hold > 0) begin
            ord_valid = 1; ord_client = IW'(c + 1); ord_setmax = 0; ord_qty = 16'd1;
            repeat (hold) begin @(posedge clk); #1; end
        end
        g_acc = resp_accept; g_rsn = int'(resp_reason);
        resp_ready = 1;
        @(posedge clk); #1;
        resp_ready = 0; ord_valid = 0; busy = 0;
        if (e_write) begin
            if (s) m_lim[c] = q; else m_acc[c] = m_acc[c] + q;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (!busy) begin
                chk("idle_ready", 32'(ord_ready), 1);
                chk("idle_we", 32'(mem_we), 0);
                chk("idle_resp_valid", 32'(resp_valid), 0);
            end else begin
                chk("busy_ready", 32'(ord_ready), 0);
                chk("rdindex", 32'(mem_rdindex), 32'(e_client));
                chk("mem_we", 32'(mem_we), 32'(e_write && (cyc - t_acc == RL + 1)));
                if (e_write && (cyc - t_acc == RL + 1)) chk("mem_wdata", mem_wdata, e_wdata);
                chk("resp_valid", 32'(resp_valid), 32'(cyc - t_acc >= e_lat - 1));
                if (resp_valid) begin
                    chk("resp_client", 32'(resp_client), 32'(e_client));
                    chk("resp_accept", 32'(resp_accept), 32'(e_accept));
                    chk("resp_reason", 32'(resp_reason), 32'(e_reason));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    bit ga, seen;
    int gr, gl, w0;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdindex", 32'(mem_rdindex), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_accept", 32'(resp_accept), 0);
        chk("rst_resp_reason", 32'(resp_reason), 0);
        chk("rst_resp_client", 32'(resp_client), 0);
        rst = 0;
        @(posedge clk); #1;
        chk("rst_ready", 32'(ord_ready), 1);
        clear_all();
        chk_en = 1;

        // Sum lands exactly on the limit: accepted and written once.
        preload(5, 16'h0064, 16'h0050);
        w0 = we_cnt;
        do_order(5, 0, 'h14, 0, ga, gr, gl);
        chk("lim_eq_accept", 32'(ga), 1);
        chk("lim_eq_reason", 32'(gr), 0);
        chk("lim_eq_we_count", 32'(we_cnt - w0), 1);
        chk("lim_eq_wdata", last_wdata, 32'h0000_0014);
        chk("lim_eq_latency", 32'(gl), 13);
        chk("lim_eq_mem", mem[5], 32'h0064_0064);

        // One over the limit: rejected, nothing written, short latency.
        preload(5, 16'h0064, 16'h0050);
        w0 = we_cnt;
        do_order(5, 0, 'h15, 0, ga, gr, gl);
        chk("over_accept", 32'(ga), 0);
        chk("over_reason", 32'(gr), 1);
        chk("over_we_count", 32'(we_cnt - w0), 0);
        chk("over_latency", 32'(gl), 6);

        preload(9, 16'hFFFF, 16'hFFF0);
        do_order(9, 0, 'h20, 0, ga, gr, gl);
        chk("ovf_reason", 32'(gr), 3);
        do_order(9, 0, 'h10, 0, ga, gr, gl);
        chk("ovf_edge_reason", 32'(gr), 3);
        do_order(9, 1, 'h1, 0, ga, gr, gl);
        chk("badlim1_reason", 32'(gr), 2);
        do_order(9, 1, 'h0, 0, ga, gr, gl);
        chk("badlim0_reason", 32'(gr), 2);
        do_order(9, 1, 'h2, 0, ga, gr, gl);
        chk("lim2_accept", 32'(ga), 1);
        do_order(9, 1, 'h200, 0, ga, gr, gl);
        chk("setmax_accept", 32'(ga), 1);
        chk("setmax_wdata", last_wdata, 32'h0200_0000);
        w0 = we_cnt;
        do_order(9, 0, 0, 0, ga, gr, gl);
        chk("qty0_accept", 32'(ga), 1);
        chk("qty0_reason", 32'(gr), 0);
        chk("qty0_we_count", 32'(we_cnt - w0), 0);
        chk("qty0_latency", 32'(gl), 6);
        preload(4, 16'hFFFF, 16'hFFEF);
        do_order(4, 0, 'h10, 0, ga, gr, gl);
        chk("max_sum_accept", 32'(ga), 1);
        chk("max_sum_mem", mem[4], 32'hFFFF_FFFF);

        // Response held for 10 cycles while a second order waits on the port.
        preload(3, 16'h1000, 16'h0000);
        do_order(3, 0, 'h10, 10, ga, gr, gl);
        chk("hold_accept", 32'(ga), 1);
        do_order(4, 0, 'h1, 0, ga, gr, gl);
        chk("after_hold_reason", 32'(gr), 3);

        // Reset in the write-strobe cycle, then in the third write-wait cycle.
        chk_en = 0;
        preload(7, 16'h0100, 16'h0000);
        for (int t = 0; t < 2; t++) begin
            ord_valid = 1; ord_client = IW'(7); ord_setmax = 0; ord_qty = 16'd5;
            @(posedge clk); #1;
            ord_valid = 0;
            repeat ((t == 0) ? RL + 1 : RL + 4) begin @(posedge clk); #1; end
            chk(t == 0 ? "wr_cycle_we" : "waitwr_cycle_we", 32'(mem_we), 32'(t == 0));
            rst = 1;
            #1;
            chk("rst_async_we", 32'(mem_we), 0);
            chk("rst_async_wdata", mem_wdata, 0);
            @(posedge clk); #1;
            rst = 0;
            #1;
            chk("rst_rel_ready", 32'(ord_ready), 1);
            chk("rst_rel_rdindex", 32'(mem_rdindex), 0);
            chk("rst_rel_client", 32'(resp_client), 0);
            seen = 0;
            repeat (20) begin @(posedge clk); #1; seen = seen | resp_valid | mem_we; end
            chk("rst_no_resp", 32'(seen), 0);
            if (t == 0) chk("rst_wr_dropped", mem[7], 32'h0100_0000);
        end
        clear_all();
        chk_en = 1;

        for (int c = 0; c < 8; c++)
            preload(c, 16'($urandom_range(16'h0080, 16'h4000)), 16'($urandom_range(0, 16'h0100)));
        preload(8, 16'hFFFF, 16'hFF00);
        for (int n = 0; n < 100; n++) begin
            int c, r, q;
            bit s;
            c = $urandom_range(0, 8);
            r = $urandom_range(0, 9);
            s = (r == 0);
            q = s ? $urandom_range(0, 'h300) : (r == 1) ? 0
              : (r <= 3) ? $urandom_range('h100, 'h400) : $urandom_range(1, 'h80);
            do_order(c, s, q, 0, ga, gr, gl);
        end
        for (int c = 0; c < 9; c++)
            chk("final_entry", mem[c], {m_lim[c][15:0], m_acc[c][15:0]});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
